tone_sequencer: RTL

Controller that sequences the 256-entry sine ROM for the audio DAC. On an ENABLE rising edge it plays three tones in fixed order (0, 1, 2). Each tone lasts TONE_CYCLES and is separated from the next by GAP_CYCLES of silence. It drives the sine ROM address, an audio gate for the DAC mux, and status outputs. It sits between the robot-status/enable logic and the SINE_WAVE ROM, on the 25 MHz clock domain.

---
 rtl/tone_sequencer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/tone_sequencer.sv
// Plays three fixed tones from the sine ROM on an ENABLE rising edge,
// with optional silent gaps between tones and optional looping.
module tone_sequencer #(
  parameter int unsigned TONE_CYCLES = 25000000,
  parameter int unsigned GAP_CYCLES  = 2500000,
  parameter int unsigned DIV_0       = 221,
  parameter int unsigned DIV_1       = 147,
  parameter int unsigned DIV_2       = 443
) (
  input  logic       CLOCK,
  input  logic       RESET_N,
  input  logic       ENABLE,
  input  logic       MODE_LOOP,
  output logic [7:0] ADDR,
  output logic       AUDIO_EN,
  output logic [1:0] TONE_IDX,
  output logic       BUSY,
  output logic       DONE
);

  localparam int unsigned STEP_W = 16;
  localparam int unsigned CNT_W  = 26;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned IDX_W  = 2;

  localparam logic [CNT_W-1:0] TONE_LAST = CNT_W'(TONE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam bit               HAS_GAP   = (GAP_CYCLES != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [CNT_W-1:0]    dur_q, dur_d;
  logic [CNT_W-1:0]    gap_q, gap_d;
  logic                en_q;
  logic                loop_q, loop_d;
  logic [ADDR_W-1:0]   addr_d;
  logic                aen_d;
  logic [IDX_W-1:0]    tone_d;
  logic                busy_d;
  logic                done_d;
  logic [STEP_W-1:0]   div_cur;
  logic [IDX_W-1:0]    tone_next;
  logic                to_idle;

  // Clocks-per-address divider for the tone currently playing.
  always_comb begin
    div_cur = STEP_W'(DIV_0);
    case (TONE_IDX)
      2'd1:    div_cur = STEP_W'(DIV_1);
      2'd2:    div_cur = STEP_W'(DIV_2);
      default: div_cur = STEP_W'(DIV_0);
    endcase
  end

  assign tone_next = (TONE_IDX == 2'd2) ? 2'd0 : IDX_W'(TONE_IDX + 2'd1);

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      step_q   <= '0;
      dur_q    <= '0;
      gap_q    <= '0;
      en_q     <= 1'b0;
      loop_q   <= 1'b0;
      ADDR     <= '0;
      AUDIO_EN <= 1'b0;
      TONE_IDX <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      dur_q    <= dur_d;
      gap_q    <= gap_d;
      en_q     <= ENABLE;
      loop_q   <= loop_d;
      ADDR     <= addr_d;
      AUDIO_EN <= aen_d;
      TONE_IDX <= tone_d;
      BUSY     <= busy_d;
      DONE     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    dur_d   = dur_q;
    gap_d   = gap_q;
    loop_d  = loop_q;
    addr_d  = ADDR;
    aen_d   = AUDIO_EN;
    tone_d  = TONE_IDX;
    busy_d  = BUSY;
    done_d  = 1'b0;
    to_idle = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ENABLE && !en_q) begin
          state_d = S_PLAY;
          tone_d  = '0;
          addr_d  = '0;
          step_d  = '0;
          dur_d   = '0;
          gap_d   = '0;
          aen_d   = 1'b1;
          busy_d  = 1'b1;
          loop_d  = MODE_LOOP;
        end
      end
      S_PLAY: begin
        if (!ENABLE) begin
          to_idle = 1'b1;
        end else if (dur_q == TONE_LAST) begin
          step_d = '0;
          dur_d  = '0;
          gap_d  = '0;
          addr_d = '0;
          if ((TONE_IDX == 2'd2) && !loop_q) begin
            to_idle = 1'b1;
            done_d  = 1'b1;
          end else if (HAS_GAP) begin
            state_d = S_GAP;
            aen_d   = 1'b0;
          end else begin
            tone_d = tone_next;
          end
        end else begin
          dur_d = dur_q + CNT_W'(1);
          if (step_q == div_cur) begin
            step_d = '0;
            addr_d = ADDR_W'(ADDR + 8'd1);
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end
      end
      S_GAP: begin
        if (!ENABLE) begin
          to_idle = 1'b1;
        end else if (gap_q == GAP_LAST) begin
          state_d = S_PLAY;
          tone_d  = tone_next;
          addr_d  = '0;
          step_d  = '0;
          dur_d   = '0;
          gap_d   = '0;
          aen_d   = 1'b1;
        end else begin
          gap_d = gap_q + CNT_W'(1);
        end
      end
      default: begin
        to_idle = 1'b1;
      end
    endcase

    // Abort and normal completion share the return to reset-like outputs.
    if (to_idle) begin
      state_d = S_IDLE;
      step_d  = '0;
      dur_d   = '0;
      gap_d   = '0;
      loop_d  = 1'b0;
      addr_d  = '0;
      aen_d   = 1'b0;
      tone_d  = '0;
      busy_d  = 1'b0;
    end
  end

endmodule
